maquina_preparo: RTL

Preparation controller on the far side of the drink-selection interface. It watches the selector's 2-bit status and 4-bit drink code and drives the selector's `TIMER` timeout input. Once a drink is confirmed, it sequences the valves through that drink's recipe with timed phases. It signals completion or error, then waits for the selector to return to idle.

---
 rtl/maquina_preparo.sv | 119 +++++++++++
 1 files changed

// File: rtl/maquina_preparo.sv
// maquina_preparo: drink preparation controller that watches the selector, runs timed
// recipe phases over the valves and reports completion or error back to the selector.
module maquina_preparo #(
  parameter int TIMEOUT_CICLOS = 50,
  parameter int T_AGUA         = 8,
  parameter int T_PO           = 4,
  parameter int T_LEITE        = 6,
  parameter int T_ENTREGA      = 3
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [1:0] STATUS,
  input  logic [3:0] BEBIDA,
  output logic       TIMER,
  output logic       AGUA,
  output logic       CAFE,
  output logic       CHA,
  output logic       LEITE,
  output logic       OCUPADO,
  output logic       PRONTO,
  output logic       ERRO,
  output logic [2:0] FASE
);
  typedef enum logic [2:0] {
    OCIOSO, CONTAGEM, FASE_AGUA, FASE_PO, FASE_LEITE, ENTREGA, FIM, S_ERRO
  } estado_t;

  function automatic logic [15:0] dur(input int t);
    return (t < 1) ? 16'd1 : 16'(t);
  endfunction

  localparam logic [15:0] D_AGUA   = dur(T_AGUA);
  localparam logic [15:0] D_PO     = dur(T_PO);
  localparam logic [15:0] D_LEITE  = dur(T_LEITE);
  localparam logic [15:0] D_LEITE2 = dur(2 * T_LEITE);
  localparam logic [15:0] D_ENT    = dur(T_ENTREGA);
  localparam logic [15:0] TMAX     = 16'(TIMEOUT_CICLOS - 1);

  estado_t     st_q, st_d;
  logic [15:0] cnt_q, cnt_d, inat_q, inat_d;
  logic [3:0]  beb_q, beb_d, prev_q;
  logic        timer_q, timer_d, pronto_q, pronto_d;
  logic        expira, leite;

  assign expira = cnt_q <= 16'd1;
  assign leite  = (beb_q == 4'd2) || (beb_q == 4'd4);

  always_comb begin
    st_d     = st_q;
    cnt_d    = cnt_q;
    inat_d   = inat_q;
    beb_d    = beb_q;
    timer_d  = 1'b0;
    pronto_d = 1'b0;
    case (st_q)
      OCIOSO: begin
        st_d   = (STATUS == 2'b01) ? CONTAGEM : STATUS[1] ? S_ERRO : OCIOSO;
        inat_d = '0;
      end
      CONTAGEM: begin
        // any change of the drink code counts as user activity
        inat_d  = (BEBIDA != prev_q) ? '0 : (inat_q >= TMAX) ? TMAX : inat_q + 16'd1;
        beb_d   = (STATUS == 2'b11) ? BEBIDA : beb_q;
        st_d    = (STATUS == 2'b11) ? ((BEBIDA inside {[4'd1:4'd4]}) ? FASE_AGUA : S_ERRO) :
                  (STATUS == 2'b10) ? S_ERRO : (STATUS == 2'b00) ? OCIOSO : CONTAGEM;
        cnt_d   = D_AGUA;
        timer_d = (st_d == CONTAGEM) && (timer_q || inat_d == TMAX);
      end
      FASE_AGUA: begin
        st_d  = expira ? FASE_PO : FASE_AGUA;
        cnt_d = expira ? D_PO : cnt_q - 16'd1;
      end
      FASE_PO: begin
        st_d  = expira ? (leite ? FASE_LEITE : ENTREGA) : FASE_PO;
        cnt_d = expira ? ((beb_q == 4'd4) ? D_LEITE2 : leite ? D_LEITE : D_ENT) : cnt_q - 16'd1;
      end
      FASE_LEITE: begin
        st_d  = expira ? ENTREGA : FASE_LEITE;
        cnt_d = expira ? D_ENT : cnt_q - 16'd1;
      end
      ENTREGA: begin
        st_d     = expira ? FIM : ENTREGA;
        cnt_d    = expira ? cnt_q : cnt_q - 16'd1;
        pronto_d = expira;
      end
      default: st_d = (STATUS == 2'b00) ? OCIOSO : st_q;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      st_q     <= OCIOSO;
      cnt_q    <= '0;
      inat_q   <= '0;
      beb_q    <= '0;
      prev_q   <= '0;
      timer_q  <= 1'b0;
      pronto_q <= 1'b0;
    end else begin
      st_q     <= st_d;
      cnt_q    <= cnt_d;
      inat_q   <= inat_d;
      beb_q    <= beb_d;
      prev_q   <= BEBIDA;
      timer_q  <= timer_d;
      pronto_q <= pronto_d;
    end
  end

  assign TIMER   = timer_q;
  assign PRONTO  = pronto_q;
  assign AGUA    = st_q == FASE_AGUA;
  assign CAFE    = (st_q == FASE_PO) && (beb_q != 4'd3);
  assign CHA     = (st_q == FASE_PO) && (beb_q == 4'd3);
  assign LEITE   = st_q == FASE_LEITE;
  assign OCUPADO = st_q inside {FASE_AGUA, FASE_PO, FASE_LEITE, ENTREGA, FIM};
  assign ERRO    = st_q == S_ERRO;
  assign FASE    = st_q;
endmodule
